// File: rtl/fifo_drain_pkg.sv
`default_nettype none
// ============================================================================
// fifo_drain_pkg
// Shared types and constants for the fifo_drain_sched read-side scheduler.
// Revision: 1.0
// ============================================================================
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BURST = 2'd2,
    STOP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sol;
    logic       eol;
    logic       sof;
  } buf_entry_t;

  localparam int NIBBLES_PER_BYTE = 2;
  localparam int BUF_DEPTH        = 2;

endpackage
`default_nettype wire

// File: rtl/fifo_drain_sched_if.sv
`default_nettype none
// ============================================================================
// fifo_drain_sched_if
// Byte stream with line/frame markers; master drives data, slave drives ready.
// Revision: 1.0
// ============================================================================
interface fifo_drain_sched_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       sol;
  logic       eol;
  logic       sof;

  modport master (output data, valid, sol, eol, sof, input ready);
  modport slave  (input data, valid, sol, eol, sof, output ready);
endinterface
`default_nettype wire

// File: rtl/fifo_drain_skid.sv
`default_nettype none
// ============================================================================
// fifo_drain_skid
// Two-entry byte buffer feeding the valid/ready output stream from its head.
// Revision: 1.0
// ============================================================================
module fifo_drain_skid
  import fifo_drain_pkg::*;
(
  input  wire logic       readclk,
  input  wire logic       reset,
  input  wire logic       push,
  input  wire buf_entry_t push_entry,
  output logic            pop,
  output logic            empty,
  fifo_drain_sched_if.master out
);

  buf_entry_t r_mem [BUF_DEPTH];
  logic       r_head;
  logic       r_tail;
  logic [1:0] r_count;
  buf_entry_t w_head;

  assign w_head    = r_mem[r_head];
  assign out.valid = (r_count != 2'd0);
  assign out.data  = w_head.data;
  assign out.sol   = w_head.sol;
  assign out.eol   = w_head.eol;
  assign out.sof   = w_head.sof;
  assign pop       = out.valid && out.ready;
  assign empty     = (r_count == 2'd0);

  // Upstream reservation guarantees push never arrives while full.
  always_ff @(posedge readclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_tail] <= push_entry;
        r_tail        <= ~r_tail;
      end
      if (pop) r_head <= ~r_head;
      r_count <= r_count + 2'(push) - 2'(pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_drain_sched.sv
`default_nettype none
// ============================================================================
// fifo_drain_sched
// Bursts nibble reads from the 8-in/4-out FIFO, packs pairs into bytes and
// streams them with line/frame markers. Optional stats: FIFO_DRAIN_STATS_EN.
// Revision: 1.0
// ============================================================================
module fifo_drain_sched
  import fifo_drain_pkg::*;
#(
  parameter int BURST_LEN   = 16,
  parameter int LINE_BYTES  = 1920,
  parameter int FRAME_LINES = 1080,
  parameter int CNT_W       = 12
) (
  input  wire logic       readclk,
  input  wire logic       reset,
  input  wire logic       enable,
  input  wire logic [3:0] fifo_dout,
  input  wire logic       fifo_empty,
  input  wire logic       fifo_almostempty,
  output logic            fifo_rd,
  fifo_drain_sched_if.master out,
  output logic            underrun_err,
  output logic            busy
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     burst_cnt
`endif
);

  localparam int BL_W = $clog2(BURST_LEN + 1);

  state_t           r_state;
  logic [BL_W-1:0]  r_burst_left;
  logic             r_phase;
  logic [1:0]       r_reserved;
  logic             r_rd_d1;
  logic             r_rd_hi_d1;
  logic [3:0]       r_lo;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [CNT_W-1:0] r_line_cnt;

  logic       w_reads_left;
  logic       w_rd_hi;
  logic       w_rsv_inc;
  logic       w_push;
  logic       w_pop;
  logic       w_buf_empty;
  buf_entry_t w_entry;

  assign w_reads_left = (r_burst_left != '0);
  assign w_rd_hi      = (r_phase == 1'(NIBBLES_PER_BYTE - 1));

  // Gated combinationally by fifo_empty so a read never lands on an empty FIFO.
  assign fifo_rd   = (r_state == BURST) && w_reads_left && !fifo_empty &&
                     (w_rd_hi || (r_reserved < 2'(BUF_DEPTH)));
  assign w_rsv_inc = fifo_rd && !w_rd_hi;
  assign w_push    = r_rd_d1 && r_rd_hi_d1;

  assign w_entry.data = {fifo_dout, r_lo};
  assign w_entry.sol  = (r_byte_cnt == '0);
  assign w_entry.eol  = (r_byte_cnt == CNT_W'(LINE_BYTES - 1));
  assign w_entry.sof  = (r_byte_cnt == '0) && (r_line_cnt == '0);

  always_ff @(posedge readclk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_burst_left <= '0;
      r_phase      <= 1'b0;
      busy         <= 1'b0;
      underrun_err <= 1'b0;
    end else begin
      if (fifo_rd) begin
        r_burst_left <= r_burst_left - 1'b1;
        r_phase      <= ~r_phase;
      end
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= FILL;
            busy    <= 1'b1;
          end else begin
            underrun_err <= 1'b0;
          end
        end
        FILL: begin
          if (!enable) begin
            r_state <= STOP;
          end else if (!fifo_almostempty && !fifo_empty) begin
            r_state      <= BURST;
            r_burst_left <= BL_W'(BURST_LEN);
          end
        end
        BURST: begin
          if (w_reads_left && fifo_empty) underrun_err <= 1'b1;
          // Bursts always finish so nibble pairing survives an enable drop.
          if (!w_reads_left) r_state <= enable ? FILL : STOP;
        end
        STOP: begin
          if (w_buf_empty && !r_rd_d1) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge readclk or negedge reset) begin
    if (!reset) begin
      r_rd_d1    <= 1'b0;
      r_rd_hi_d1 <= 1'b0;
      r_lo       <= 4'd0;
      r_reserved <= 2'd0;
      r_byte_cnt <= '0;
      r_line_cnt <= '0;
    end else begin
      r_rd_d1    <= fifo_rd;
      r_rd_hi_d1 <= w_rd_hi;
      if (r_rd_d1 && !r_rd_hi_d1) r_lo <= fifo_dout;
      case ({w_rsv_inc, w_pop})
        2'b10:   r_reserved <= r_reserved + 2'd1;
        2'b01:   r_reserved <= r_reserved - 2'd1;
        default: r_reserved <= r_reserved;
      endcase
      if (r_state == IDLE) begin
        r_byte_cnt <= '0;
        r_line_cnt <= '0;
      end else if (w_push) begin
        if (r_byte_cnt == CNT_W'(LINE_BYTES - 1)) begin
          r_byte_cnt <= '0;
          r_line_cnt <= (r_line_cnt == CNT_W'(FRAME_LINES - 1)) ? '0 : r_line_cnt + 1'b1;
        end else begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  always_ff @(posedge readclk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
      burst_cnt <= 16'd0;
    end else if (r_state == IDLE) begin
      stall_cnt <= 16'd0;
      burst_cnt <= 16'd0;
    end else begin
      if (!w_buf_empty && !w_pop && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if ((r_state == BURST) && !w_reads_left && (burst_cnt != 16'hFFFF))
        burst_cnt <= burst_cnt + 16'd1;
    end
  end
`endif

  fifo_drain_skid u_skid (
    .readclk    (readclk),
    .reset      (reset),
    .push       (w_push),
    .push_entry (w_entry),
    .pop        (w_pop),
    .empty      (w_buf_empty),
    .out        (out)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_sched.sv
`default_nettype none
// ============================================================================
// tb_fifo_drain_sched
// Directed bench with a behavioural nibble FIFO and a byte scoreboard.
// Revision: 1.0
// ============================================================================
module tb_fifo_drain_sched;

  localparam int LB = 4;
  localparam int FL = 2;
  localparam int AE_THRESH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] fifo_dout = 4'd0;
  logic       fifo_empty = 1'b1;
  logic       fifo_almostempty = 1'b1;
  logic       fifo_rd;
  logic       underrun_err;
  logic       busy;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] burst_cnt;
`endif

  fifo_drain_sched_if sif ();

  fifo_drain_sched #(
    .BURST_LEN   (16),
    .LINE_BYTES  (LB),
    .FRAME_LINES (FL),
    .CNT_W       (12)
  ) dut (
    .readclk          (clk),
    .reset            (reset),
    .enable           (enable),
    .fifo_dout        (fifo_dout),
    .fifo_empty       (fifo_empty),
    .fifo_almostempty (fifo_almostempty),
    .fifo_rd          (fifo_rd),
    .out              (sif),
    .underrun_err     (underrun_err),
    .busy             (busy)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .stall_cnt        (stall_cnt),
    .burst_cnt        (burst_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          popped = 0;
  logic [3:0]  nib_q[$];
  logic [10:0] exp_q[$];
  logic [3:0]  pend;
  logic        half = 1'b0;
  int          idx = 0;
  logic [3:0]  model_nib;
  logic [10:0] exp_e;
  logic [10:0] obs_e;
  logic        stall_prev = 1'b0;
  logic [10:0] prev_e;

  // Behavioural FIFO: data one cycle after the read, flags updated on the edge.
  always @(posedge clk) begin
    if (fifo_rd) begin
      total++;
      assert (nib_q.size() != 0) else begin
        bad++;
        $error("FAIL fifo_read_empty: observed size=%0d expected size>0", nib_q.size());
      end
      if (nib_q.size() != 0) begin
        model_nib = nib_q.pop_front();
        fifo_dout <= model_nib;
      end
    end
    fifo_empty       <= (nib_q.size() == 0);
    fifo_almostempty <= (nib_q.size() < AE_THRESH);
  end

  always @(negedge clk) begin
    obs_e = {sif.data, sif.sol, sif.eol, sif.sof};
    if (reset && stall_prev) begin
      total++;
      assert ((sif.valid === 1'b1) && (obs_e === prev_e)) else begin
        bad++;
        $error("FAIL hold_stable: observed v=%0b e=%0h expected v=1 e=%0h", sif.valid, obs_e, prev_e);
      end
    end
    if (reset && sif.valid && sif.ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_extra: observed byte e=%0h expected none", obs_e);
      end
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        total++;
        assert (obs_e === exp_e) else begin
          bad++;
          $error("FAIL sb_byte%0d: observed {data,sol,eol,sof}=%0h expected %0h", popped, obs_e, exp_e);
        end
      end
      popped++;
    end
    stall_prev = reset && sif.valid && !sif.ready;
    prev_e     = obs_e;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_nib(input logic [3:0] n);
    nib_q.push_back(n);
    if (!half) begin
      pend = n;
      half = 1'b1;
    end else begin
      exp_q.push_back({n, pend, (idx % LB) == 0, (idx % LB) == LB - 1, (idx % (LB * FL)) == 0});
      idx++;
      half = 1'b0;
    end
  endtask

  task automatic count_rd(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (fifo_rd) n++;
    end
  endtask

  task automatic wait_rd(input int budget);
    int n = 0;
    while (fifo_rd !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rd_timeout", fifo_rd, 1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (sif.valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid_timeout", sif.valid, 1);
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  initial begin
    int n;
    int p0;
    reset     = 1'b0;
    enable    = 1'b0;
    sif.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_stream", {sif.valid, sif.data, sif.sol, sif.eol, sif.sof}, 0);
    chk("rst_busy_err", {busy, underrun_err}, 0);
    reset = 1'b1;

    // Basic burst: 16 nibbles, latency and first byte markers
    for (int i = 0; i < 16; i++) push_nib(4'((i % 15) + 1));
    @(posedge clk);
    #1;
    enable = 1'b1;
    @(negedge clk);
    wait_rd(20);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) chk("lat_valid_t2", sif.valid, 0);
      if (i == 3) begin
        chk("lat_valid_t3", sif.valid, 1);
        chk("first_byte", {sif.data, sif.sol, sif.eol, sif.sof}, {8'h21, 3'b101});
      end
      if (fifo_rd) n++;
      @(negedge clk);
    end
    chk("basic_reads", n, 16);
    chk("basic_busy", busy, 1);
    wait_sb(40);

    // Backpressure: only two bytes reserved, so reads stop after 4 nibbles
    @(posedge clk);
    #1;
    sif.ready = 1'b0;
    for (int i = 0; i < 16; i++) push_nib(4'(15 - i));
    count_rd(25, n);
    chk("bp_reads", n, 4);
    chk("bp_valid", sif.valid, 1);
    @(posedge clk);
    #1;
    sif.ready = 1'b1;
    count_rd(40, n);
    chk("bp_rest_reads", n, 12);
    wait_sb(20);
    chk("bp_fifo_drained", nib_q.size(), 0);
    chk("no_underrun_yet", underrun_err, 0);

    // Underrun: FIFO runs dry after 5 nibbles, then refills
    p0 = popped;
    for (int i = 0; i < 5; i++) push_nib(4'(i + 3));
    count_rd(20, n);
    chk("ur_reads", n, 5);
    chk("ur_rd_low", fifo_rd, 0);
    chk("ur_flag", underrun_err, 1);
    chk("ur_busy", busy, 1);
    for (int i = 0; i < 11; i++) push_nib(4'(i + 8));
    count_rd(40, n);
    chk("ur_rest_reads", n, 11);
    wait_sb(20);
    chk("ur_bytes", popped - p0, 8);
    chk("ur_sticky", underrun_err, 1);

    // Stop: enable dropped mid-burst, burst completes then drains to IDLE
    for (int i = 0; i < 16; i++) push_nib(4'(i ^ 5));
    @(negedge clk);
    wait_rd(30);
    n = 1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) enable = 1'b0;
      @(negedge clk);
      if (fifo_rd) n++;
    end
    chk("stop_reads", n, 16);
    wait_sb(20);
    wait_idle(20);
    @(negedge clk);
    chk("stop_busy", busy, 0);
    chk("stop_err_cleared", underrun_err, 0);
    idx = 0;

    // Asynchronous reset mid-burst clears outputs at once
    enable    = 1'b1;
    sif.ready = 1'b0;
    for (int i = 0; i < 16; i++) push_nib(4'(i) | 4'h8);
    @(negedge clk);
    wait_rd(30);
    repeat (8) @(negedge clk);
    chk("pre_rst_valid", sif.valid, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_outs", {fifo_rd, sif.valid, sif.data, sif.sol, sif.eol, sif.sof, busy, underrun_err}, 0);
    exp_q.delete();
    nib_q.delete();
    half      = 1'b0;
    idx       = 0;
    enable    = 1'b0;
    sif.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // After reset a fresh frame starts
    enable = 1'b1;
    for (int i = 0; i < 16; i++) push_nib(4'(i + 2));
    wait_sb(80);
    chk("post_rst_err", underrun_err, 0);
    @(posedge clk);
    #1;
    enable = 1'b0;
    wait_idle(30);
    idx = 0;

`ifdef FIFO_DRAIN_STATS_EN
    // Three bursts with 7 stalled cycles
    sif.ready = 1'b0;
    for (int i = 0; i < 48; i++) push_nib(4'(i * 3));
    enable = 1'b1;
    @(negedge clk);
    wait_valid(40);
    repeat (7) @(posedge clk);
    #1;
    sif.ready = 1'b1;
    wait_sb(200);
    repeat (4) @(negedge clk);
    chk("stats_burst_cnt", burst_cnt, 3);
    chk("stats_stall_cnt", stall_cnt, 7);
    @(posedge clk);
    #1;
    enable = 1'b0;
    wait_idle(30);
    @(negedge clk);
    chk("stats_cleared", {stall_cnt, burst_cnt}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_drain_sched.md
Name: fifo_drain_sched

Overview:
- Read-side scheduler for the 8-in/4-out hardware FIFO in the MIPI-to-pSRAM video path.
- Waits for the FIFO to reach its fill threshold, then issues nibble reads in fixed-length bursts.
- Re-packs nibble pairs into bytes and presents them on a valid/ready stream with start-of-line, end-of-line and start-of-frame markers.
- Runs entirely in the FIFO read-clock domain.

Parameters:
- BURST_LEN, 16, nibble reads per burst; must be even and at least 2.
- LINE_BYTES, 1920, output bytes per video line.
- FRAME_LINES, 1080, lines per frame.
- CNT_W, 12, width of the byte and line counters; must hold max(LINE_BYTES, FRAME_LINES).

Ports:
- readclk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-low; block is held in reset while low.
- enable  in  1  run request; level sensitive.
- fifo_dout  in  4  FIFO read data, valid one cycle after fifo_rd.
- fifo_empty  in  1  FIFO empty flag.
- fifo_almostempty  in  1  FIFO below fill threshold.
- fifo_rd  out  1  active-high read request, one nibble per cycle.
- out_data  out  8  packed byte: first nibble in [3:0], second in [7:4].
- out_valid  out  1  byte available.
- out_ready  in  1  downstream accept.
- out_sol  out  1  qualifies out_data as the first byte of a line.
- out_eol  out  1  qualifies out_data as the last byte of a line.
- out_sof  out  1  qualifies out_data as the first byte of a frame.
- underrun_err  out  1  sticky: FIFO ran empty mid-burst.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: every output is 0; FSM=IDLE; counters, reservation count and byte buffer are cleared. Asserting reset mid-burst discards all in-flight data.
- FSM states:
  - IDLE to FILL when enable=1.
  - FILL to BURST when fifo_almostempty=0 and fifo_empty=0. Burst nibble counter is set to BURST_LEN.
  - BURST to FILL when BURST_LEN reads have been issued and enable=1.
  - BURST to STOP when the burst completes and enable=0.
  - STOP to IDLE when the buffer is empty and no read is in flight.
  - FILL to STOP when enable=0.
- Read issue rules (BURST only):
  - Nibble phase toggles on every issued read.
  - A low nibble is issued only if fifo_empty=0 and reserved<2. Issuing it increments reserved.
  - A high nibble is issued whenever fifo_empty=0; its byte slot is already reserved.
  - reserved decrements on each out_valid&&out_ready. Simultaneous increment and decrement leaves it unchanged.
- Latency: low read at cycle t and high read at t+1 give out_valid=1 at t+3 (byte registered at the end of t+2). Sustained throughput is 1 byte per 2 cycles.
- Byte buffer is a 2-entry FIFO of {byte, sol, eol, sof}. It never overflows by construction. out_* are driven from the head entry.
- Output stream rules:
  - out_valid, once high, holds with stable data until out_ready.
  - out_ready is ignored while out_valid=0.
- Counters advance on each byte written into the buffer:
  - byte_cnt wraps from LINE_BYTES-1 to 0.
  - line_cnt increments at each wrap and wraps from FRAME_LINES-1 to 0.
  - sol = (byte_cnt==0); eol = (byte_cnt==LINE_BYTES-1); sof = sol && line_cnt==0.
- Underrun: fifo_empty=1 inside BURST with reads remaining:
  - No read is issued and the burst pauses; it resumes when fifo_empty=0.
  - underrun_err sets and stays set until enable=0 in IDLE.
- enable deasserted mid-burst: the current burst is completed, which keeps nibble pairing intact; then STOP drains the buffer.
- Counters reset only in IDLE, so re-enable starts a new frame.
- busy = (state != IDLE).

Optional Feature:
- Macro FIFO_DRAIN_STATS_EN.
- Defined: adds outputs stall_cnt[15:0] and burst_cnt[15:0]. Both clear in IDLE and saturate at 16'hFFFF.
  - stall_cnt counts cycles with out_valid && !out_ready.
  - burst_cnt counts completed bursts.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fifo_drain_pkg holds:
  - the state enum (IDLE, FILL, BURST, STOP);
  - the buffer entry struct {data[7:0], sol, eol, sof};
  - constant NIBBLES_PER_BYTE=2.
- One sub-module, fifo_drain_skid: the 2-entry byte buffer with valid/ready output.

Test Plan:
- Basic burst: enable=1, almostempty=0, empty=0, out_ready=1, nibbles 1,2,3,4 → fifo_rd high 16 cycles; out_data=8'h21 at t+3 with out_sol=out_sof=1, then 8'h43.
- Backpressure: out_ready=0 during burst → at most 2 low-nibble reads outstanding; fifo_rd stops after the 4th nibble; out_data stable. Release → bytes in order, none lost.
- Underrun: empty=1 after 5 nibbles → fifo_rd=0, underrun_err=1. empty=0 → remaining 11 reads issued, 8 bytes total.
- Line/frame markers: LINE_BYTES=4, FRAME_LINES=2, 16 bytes streamed → sol on bytes 0,4,8,12; eol on 3,7,11,15; sof on 0 and 8.
- Stop/reset: enable=0 mid-burst → burst finishes, state reaches IDLE after drain, busy=0. Reset low mid-burst → all outputs 0 immediately.
- With FIFO_DRAIN_STATS_EN: 3 bursts with out_ready low 7 cycles → burst_cnt=3, stall_cnt=7.
